// File: rtl/vit_enc_ctrl.sv
// Frame sequencer for a (2,1,3) convolutional encoder: pulls message bits,
// appends TAIL zero flush bits and marks symbol-valid / last-symbol cycles.
//
// state | meaning
// IDLE  | waiting for start; encoder held
// DATA  | accepting message bits; encoder shifts on each accepted bit
// TAIL  | shifting TAIL zero bits to flush encoder memory
// DONE  | one-cycle frame-end pulse; encoder held
module vit_enc_ctrl #(
   parameter int LEN_W = 8,
   parameter int TAIL  = 3
) (
   input  logic             clock_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [LEN_W-1:0] frame_len_i,
   input  logic             bit_in_i,
   input  logic             bit_valid_i,
   output logic             bit_ready_o,
   output logic             enc_ux_o,
   output logic             enc_hold_o,
   output logic             sym_valid_o,
   output logic             sym_last_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             start_err_o
);

   localparam int TW = (TAIL > 1) ? $clog2(TAIL) : 1;
   localparam logic [TW-1:0] TAIL_LAST = TW'(TAIL - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      TAIL_S = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [TW-1:0]    tail_q, tail_d;
   logic             sym_valid_q, sym_valid_d;
   logic             sym_last_q, sym_last_d;

   logic             bit_ready;
   logic             enc_hold;
   logic             enc_ux;
   logic             last_shift;
   logic [LEN_W-1:0] len_m1;

   assign len_m1 = len_q - LEN_W'(1);

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         tail_q      <= '0;
         sym_valid_q <= 1'b0;
         sym_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         tail_q      <= tail_d;
         sym_valid_q <= sym_valid_d;
         sym_last_q  <= sym_last_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      tail_d     = tail_q;
      bit_ready  = 1'b0;
      enc_hold   = 1'b1;
      enc_ux     = 1'b0;
      last_shift = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               len_d   = frame_len_i;
               cnt_d   = '0;
               tail_d  = '0;
               state_d = (frame_len_i != '0) ? DATA : TAIL_S;
            end
         end
         DATA: begin
            bit_ready = 1'b1;
            enc_hold  = ~bit_valid_i;
            enc_ux    = bit_in_i & bit_valid_i;
            if (bit_valid_i) begin
               cnt_d = cnt_q + LEN_W'(1);
               if (cnt_q == len_m1) begin
                  state_d = TAIL_S;
               end
            end
         end
         TAIL_S: begin
            enc_hold = 1'b0;
            tail_d   = tail_q + TW'(1);
            if (tail_q == TAIL_LAST) begin
               state_d    = DONE;
               last_shift = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A shift at this edge means the encoder output is a fresh symbol next cycle.
   assign sym_valid_d = ~enc_hold;
   assign sym_last_d  = last_shift;

   assign bit_ready_o = bit_ready;
   assign enc_hold_o  = enc_hold;
   assign enc_ux_o    = enc_ux;
   assign sym_valid_o = sym_valid_q;
   assign sym_last_o  = sym_last_q;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);
   assign start_err_o = start_i & (state_q != IDLE);

endmodule
